// File: rtl/memory_controller_if.sv
// rtl/memory_controller_if.sv - processor, bulk-load and dump bus of the memory controller
interface memory_controller_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] proc_address;
  logic                  proc_readwriteN;
  logic [DATA_WIDTH-1:0] proc_data_w;
  logic [DATA_WIDTH-1:0] proc_data_r;
  logic                  proc_enable;

  logic                  load_start;
  logic                  load_valid;
  logic                  load_ready;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;
  logic                  load_done;

  logic                  dump_start;
  logic                  dump_valid;
  logic                  dump_ready;
  logic [DATA_WIDTH-1:0] dump_data;
  logic [ADDR_WIDTH-1:0] dump_addr;

  modport master (
    output proc_address, proc_readwriteN, proc_data_w,
    output load_start, load_valid, load_data, load_last,
    output dump_start, dump_ready,
    input  proc_data_r, proc_enable, load_ready, load_done,
    input  dump_valid, dump_data, dump_addr
  );

  modport slave (
    input  proc_address, proc_readwriteN, proc_data_w,
    input  load_start, load_valid, load_data, load_last,
    input  dump_start, dump_ready,
    output proc_data_r, proc_enable, load_ready, load_done,
    output dump_valid, dump_data, dump_addr
  );
endinterface

// File: rtl/memory_controller.sv
// rtl/memory_controller.sv - 32x16 data memory with load/run/dump controller gating the processor
module memory_controller #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  memory_controller_if.slave bus
);
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DUMP = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] load_ptr;
  logic [ADDR_WIDTH-1:0] dump_ptr;
  logic [DATA_WIDTH-1:0] proc_data_q;
  logic                  load_done_q;

  logic load_hs;
  logic load_end;
  logic dump_hs;
  logic dump_end;

  // load_ready is 1 throughout LOAD, so any valid word there is a handshake
  assign load_hs  = (state == ST_LOAD) && bus.load_valid;
  assign load_end = load_hs && (bus.load_last || (load_ptr == LAST_ADDR));
  assign dump_hs  = (state == ST_DUMP) && bus.dump_ready;
  assign dump_end = dump_hs && (dump_ptr == LAST_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD: if (load_end) state_nxt = ST_RUN;
      ST_RUN: begin
        if (bus.load_start)      state_nxt = ST_LOAD;
        else if (bus.dump_start) state_nxt = ST_DUMP;
      end
      ST_DUMP: if (dump_end) state_nxt = ST_RUN;
      default: state_nxt = ST_LOAD;
    endcase
  end

  always_comb begin
    bus.proc_enable = (state == ST_RUN);
    bus.load_ready  = (state == ST_LOAD);
    bus.dump_valid  = (state == ST_DUMP);
    bus.dump_data   = '0;
    bus.dump_addr   = '0;
    if (state == ST_DUMP) begin
      bus.dump_data = mem[dump_ptr];
      bus.dump_addr = dump_ptr;
    end
    bus.proc_data_r = proc_data_q;
    bus.load_done   = load_done_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      load_ptr    <= '0;
      dump_ptr    <= '0;
      proc_data_q <= '0;
      load_done_q <= 1'b0;
    end else begin
      load_done_q <= load_end;
      case (state)
        ST_LOAD: begin
          if (load_hs) begin
            mem[load_ptr] <= bus.load_data;
            load_ptr      <= load_end ? '0 : load_ptr + 1'b1;
          end
        end
        ST_RUN: begin
          // the processor access happens even on the edge that leaves RUN
          if (bus.proc_readwriteN) begin
            proc_data_q <= mem[bus.proc_address];
          end else begin
            mem[bus.proc_address] <= bus.proc_data_w;
          end
          if (bus.load_start) begin
            load_ptr <= '0;
          end else if (bus.dump_start) begin
            dump_ptr <= '0;
          end
        end
        ST_DUMP: begin
          if (dump_hs) begin
            dump_ptr <= dump_ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
